// File: rtl/uart_tx_fifo.sv
// UART transmitter with integrated TX FIFO, configurable framing and runtime baud divisor.
// Define UART_TX_CTS_EN to add the cts_n flow-control input (2-flop synchronised).
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_en,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          txd
`ifdef UART_TX_CTS_EN
  ,
  input  logic                          cts_n
`endif
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = 4;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [FIFO_DEPTH-1:0][DATA_BITS-1:0] mem;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 push, pop, push_q, avail, start_ok, cts_ok;
  logic [DATA_BITS-1:0] head;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [DIV_WIDTH-1:0] div_lat, baud_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic                 bit_end, last_data, last_stop;

  // ---------------- FIFO ----------------
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign wr_ready   = !fifo_full;
  assign fifo_count = count;
  assign push       = wr_valid && !fifo_full;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      push_q <= 1'b0;
    end else begin
      push_q <= push;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The entry written on the previous edge is hidden from the FSM for one cycle.
  assign avail = (count - CW'(push_q)) != '0;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;
  always_ff @(posedge clk) begin
    if (rst) cts_sync <= 2'b11;
    else     cts_sync <= {cts_sync[0], cts_n};
  end
  assign cts_ok = !cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  assign start_ok  = avail && tx_en && cts_ok;
  assign bit_end   = (baud_cnt == '0);
  assign last_data = (bit_cnt == BCW'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == BCW'(STOP_BITS - 1));

  // ---------------- FSM: state register + datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      txd      <= 1'b1;
      shreg    <= '0;
      par_bit  <= 1'b0;
      div_lat  <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        shreg    <= head;
        par_bit  <= (PARITY == 1) ? ~^head : ^head;
        div_lat  <= baud_div;
        baud_cnt <= baud_div;
        bit_cnt  <= '0;
        txd      <= 1'b0;
      end else if (state != S_IDLE) begin
        if (!bit_end) begin
          baud_cnt <= baud_cnt - DIV_WIDTH'(1);
        end else begin
          baud_cnt <= div_lat;
          case (state)
            S_START: begin
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= '0;
            end
            S_DATA: begin
              if (last_data) begin
                txd     <= (PARITY != 0) ? par_bit : 1'b1;
                bit_cnt <= '0;
              end else begin
                txd     <= shreg[0];
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + BCW'(1);
              end
            end
            S_PARITY: begin
              txd     <= 1'b1;
              bit_cnt <= '0;
            end
            S_STOP: begin
              if (!last_stop) bit_cnt <= bit_cnt + BCW'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE:   if (start_ok) begin pop = 1'b1; state_nxt = S_START; end
      S_START:  if (bit_end) state_nxt = S_DATA;
      S_DATA:   if (bit_end && last_data) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP: begin
        if (bit_end && last_stop) begin
          if (start_ok) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy    = (state != S_IDLE);
    tx_done = (state == S_STOP) && (state_nxt == S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: four framing variants, per-sample txd checked against a bit-list model.
module tb_uart_tx_fifo;
  localparam int NU = 4;
  localparam int DB [NU] = '{8, 7, 7, 8};
  localparam int PB [NU] = '{0, 2, 1, 0};
  localparam int SB [NU] = '{1, 1, 1, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [NU], tx_en [NU], wr_valid [NU], wr_ready [NU];
  logic        fifo_empty [NU], fifo_full [NU], busy [NU], tx_done [NU], txd [NU];
  logic [15:0] baud_div [NU];
  logic [7:0]  wr_data [NU];
  logic [2:0]  fifo_count [NU];
`ifdef UART_TX_CTS_EN
  logic        cts_n [NU];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < NU; g++) begin : g_u
    uart_tx_fifo #(.DATA_BITS(DB[g]), .FIFO_DEPTH(4), .PARITY(PB[g]),
                   .STOP_BITS(SB[g]), .DIV_WIDTH(16)) dut (
      .clk(clk), .rst(rst[g]), .tx_en(tx_en[g]), .baud_div(baud_div[g]),
      .wr_data(wr_data[g][DB[g]-1:0]), .wr_valid(wr_valid[g]), .wr_ready(wr_ready[g]),
      .fifo_count(fifo_count[g]), .fifo_empty(fifo_empty[g]), .fifo_full(fifo_full[g]),
      .busy(busy[g]), .tx_done(tx_done[g]), .txd(txd[g])
`ifdef UART_TX_CTS_EN
      , .cts_n(cts_n[g])
`endif
    );
  end

  task automatic push_many(input int u, input logic [7:0] q[$]);
    foreach (q[i]) begin
      wr_valid[u] = 1'b1;
      wr_data[u]  = q[i];
      @(negedge clk);
    end
    wr_valid[u] = 1'b0;
  endtask

  // Waits for the start bit, then checks every sample of the chained frames in q.
  // Frame 0 uses divisor d0; baud_div is switched to d1 during frame 0, later frames use d1.
  task automatic run_frames(input int u, input logic [7:0] q[$], input int d0, input int d1,
                            input string nm, output int lat);
    logic exp_s[$];
    int   s_len, bad_at, done_cnt, done_at, busy_cnt, busy_pre;
    logic got_bad, exp_bad;
    exp_s = {};
    for (int f = 0; f < q.size(); f++) begin
      int   d;
      logic p;
      logic bits[$];
      d = (f == 0) ? d0 : d1;
      bits = {};
      bits.push_back(1'b0);
      p = 1'b0;
      for (int i = 0; i < DB[u]; i++) begin
        bits.push_back(q[f][i]);
        p = p ^ q[f][i];
      end
      if (PB[u] == 2) bits.push_back(p);
      else if (PB[u] == 1) bits.push_back(~p);
      for (int i = 0; i < SB[u]; i++) bits.push_back(1'b1);
      foreach (bits[b]) repeat (d + 1) exp_s.push_back(bits[b]);
    end
    s_len = exp_s.size();
    lat = 0;
    busy_pre = 0;
    while (txd[u] !== 1'b0 && lat < 2000) begin
      if (busy[u] === 1'b1) busy_pre++;
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (txd[u] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start: txd=%b after %0d cycles, required 0", nm, txd[u], lat);
      return;
    end
    bad_at = -1; done_cnt = 0; done_at = -1; busy_cnt = 0;
    got_bad = 1'b0; exp_bad = 1'b0;
    for (int k = 0; k < s_len; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) baud_div[u] = 16'(d1);
      if (txd[u] !== exp_s[k] && bad_at < 0) begin
        bad_at = k; got_bad = txd[u]; exp_bad = exp_s[k];
      end
      if (tx_done[u] === 1'b1) begin done_cnt++; done_at = k; end
      if (busy[u] === 1'b1) busy_cnt++;
    end
    @(negedge clk);
    if (bad_at >= 0) begin
      n_fail++;
      $display("FAIL %s txd: sample %0d got %b required %b", nm, bad_at, got_bad, exp_bad);
    end
    n_tests++;
    if (done_cnt != 1 || done_at != s_len - 1 || tx_done[u] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s tx_done: %0d pulses last at %0d, required 1 at %0d", nm, done_cnt, done_at, s_len - 1);
    end
    n_tests++;
    if (busy_cnt != s_len || busy_pre != 0 || busy[u] !== 1'b0 || txd[u] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy: %0d busy cycles (%0d before start), idle busy=%b txd=%b, required %0d/0/0/1",
               nm, busy_cnt, busy_pre, busy[u], txd[u], s_len);
    end
  endtask

  task automatic test_reset;
    logic [8:0] got;
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      got = {txd[u], busy[u], tx_done[u], fifo_count[u], fifo_empty[u], fifo_full[u], wr_ready[u]};
      n_tests++;
      if (got !== 9'b1_0_0_000_1_0_1) begin
        n_fail++;
        $display("FAIL reset u%0d: outputs %b, required 100000101", u, got);
      end
      rst[u] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      got = {txd[u], busy[u], tx_done[u], fifo_count[u], fifo_empty[u], fifo_full[u], wr_ready[u]};
      n_tests++;
      if (got !== 9'b1_0_0_000_1_0_1) begin
        n_fail++;
        $display("FAIL post_reset u%0d: outputs %b, required 100000101", u, got);
      end
    end
  endtask

  task automatic test_basic;
    logic [7:0] q[$];
    int lat;
    q = {};
    q.push_back(8'hA5);
    baud_div[0] = 16'd3;
    tx_en[0] = 1'b1;
    push_many(0, q);
    run_frames(0, q, 3, 3, "8n1_a5", lat);
    n_tests++;
    if (lat != 2) begin
      n_fail++;
      $display("FAIL latency: start bit %0d edges after write, required 2", lat);
    end
  endtask

  task automatic test_parity;
    logic [7:0] q[$];
    int lat;
    q = {};
    q.push_back(8'h55);
    for (int u = 1; u <= 2; u++) begin
      baud_div[u] = 16'd1;
      tx_en[u] = 1'b1;
      push_many(u, q);
      run_frames(u, q, 1, 1, (u == 1) ? "even_55" : "odd_55", lat);
    end
  endtask

  task automatic test_stop2;
    logic [7:0] q[$];
    int lat;
    q = {};
    q.push_back(8'h00);
    q.push_back(8'hFF);
    baud_div[3] = 16'd0;
    tx_en[3] = 1'b1;
    push_many(3, q);
    run_frames(3, q, 0, 0, "stop2", lat);
  endtask

  task automatic test_fifo_full;
    logic [7:0] q[$];
    logic [4:0] got;
    int lat;
    q = {};
    tx_en[0] = 1'b0;
    baud_div[0] = 16'd2;
    for (int i = 0; i < 5; i++) begin
      wr_valid[0] = 1'b1;
      wr_data[0]  = 8'($urandom);
      got = {wr_ready[0], fifo_full[0], fifo_count[0]};
      n_tests++;
      if (i < 4) begin
        q.push_back(wr_data[0]);
        if (got !== {1'b1, 1'b0, 3'(i)}) begin
          n_fail++;
          $display("FAIL fill_%0d: ready/full/count %b, required %b", i, got, {1'b1, 1'b0, 3'(i)});
        end
      end else if (got !== 5'b0_1_100) begin
        n_fail++;
        $display("FAIL full: ready/full/count %b, required 01100", got);
      end
      @(negedge clk);
    end
    wr_valid[0] = 1'b0;
    n_tests++;
    if (fifo_count[0] !== 3'd4) begin
      n_fail++;
      $display("FAIL refused_write: count %0d, required 4", fifo_count[0]);
    end
    tx_en[0] = 1'b1;
    run_frames(0, q, 2, 2, "drain4", lat);
    begin
      int anom = 0;
      repeat (20) begin
        if (txd[0] !== 1'b1 || fifo_empty[0] !== 1'b1) anom++;
        @(negedge clk);
      end
      n_tests++;
      if (anom != 0) begin
        n_fail++;
        $display("FAIL drain_idle: %0d non-idle cycles, required 0", anom);
      end
    end
  endtask

  task automatic test_tx_en_gate;
    logic [7:0] q0[$], q1[$];
    int lat, anom;
    q0 = {}; q1 = {};
    q0.push_back(8'($urandom));
    q1.push_back(8'($urandom));
    tx_en[1] = 1'b0;
    baud_div[1] = 16'd1;
    push_many(1, {q0, q1});
    tx_en[1] = 1'b1;
    for (int i = 0; i < 20 && txd[1] !== 1'b0; i++) @(negedge clk);
    tx_en[1] = 1'b0;
    run_frames(1, q0, 1, 1, "gate_first", lat);
    anom = 0;
    repeat (10) begin
      if (txd[1] !== 1'b1 || fifo_count[1] !== 3'd1) anom++;
      @(negedge clk);
    end
    n_tests++;
    if (anom != 0) begin
      n_fail++;
      $display("FAIL gate_hold: %0d cycles not idle with 1 queued, required 0", anom);
    end
    tx_en[1] = 1'b1;
    run_frames(1, q1, 1, 1, "gate_second", lat);
  endtask

  task automatic test_reset_mid;
    logic [7:0] q[$];
    logic [5:0] got;
    int anom;
    q = {};
    for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
    baud_div[0] = 16'd3;
    tx_en[0] = 1'b1;
    push_many(0, q);
    repeat (10) @(negedge clk);
    n_tests++;
    if (busy[0] !== 1'b1 || fifo_count[0] !== 3'd3) begin
      n_fail++;
      $display("FAIL pre_reset: busy=%b count=%0d, required 1/3", busy[0], fifo_count[0]);
    end
    rst[0] = 1'b1;
    @(negedge clk);
    got = {txd[0], busy[0], fifo_count[0], fifo_empty[0]};
    n_tests++;
    if (got !== 6'b1_0_000_1) begin
      n_fail++;
      $display("FAIL mid_reset: txd/busy/count/empty %b, required 100001", got);
    end
    rst[0] = 1'b0;
    anom = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) anom++;
    end
    n_tests++;
    if (anom != 0) begin
      n_fail++;
      $display("FAIL after_reset: %0d active cycles, required 0", anom);
    end
  endtask

`ifdef UART_TX_CTS_EN
  task automatic test_cts;
    logic [7:0] q[$];
    int lat, anom;
    q = {};
    q.push_back(8'h3C);
    cts_n[0] = 1'b1;
    baud_div[0] = 16'd1;
    tx_en[0] = 1'b1;
    repeat (3) @(negedge clk);
    push_many(0, q);
    anom = 0;
    repeat (20) begin
      if (txd[0] !== 1'b1 || fifo_count[0] !== 3'd1) anom++;
      @(negedge clk);
    end
    n_tests++;
    if (anom != 0) begin
      n_fail++;
      $display("FAIL cts_hold: %0d cycles not held, required 0", anom);
    end
    cts_n[0] = 1'b0;
    @(negedge clk);
    fork
      begin
        repeat (8) @(negedge clk);
        cts_n[0] = 1'b1;
      end
    join_none
    run_frames(0, q, 1, 1, "cts_frame", lat);
    n_tests++;
    if (lat != 2) begin
      n_fail++;
      $display("FAIL cts_latency: start %0d edges after first sampling edge, required 2", lat);
    end
    cts_n[0] = 1'b0;
  endtask
`endif

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      int u, n, d0, d1, lat;
      logic [7:0] q[$];
      u  = int'($urandom_range(0, NU - 1));
      n  = int'($urandom_range(1, 3));
      d0 = int'($urandom_range(0, 3));
      d1 = int'($urandom_range(0, 3));
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      baud_div[u] = 16'(d0);
      tx_en[u] = 1'b1;
      push_many(u, q);
      run_frames(u, q, d0, d1, "random", lat);
      n_tests++;
      if (lat != 3 - n || fifo_count[u] !== 3'd0) begin
        n_fail++;
        $display("FAIL random_%0d: latency %0d count %0d, required %0d/0", it, lat, fifo_count[u], 3 - n);
      end
    end
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      rst[u] = 1'b1;
      tx_en[u] = 1'b0;
      wr_valid[u] = 1'b0;
      wr_data[u] = 8'h00;
      baud_div[u] = 16'd3;
`ifdef UART_TX_CTS_EN
      cts_n[u] = 1'b0;
`endif
    end
    test_reset;
    test_basic;
    test_parity;
    test_stop2;
    test_fifo_full;
    test_tx_en_gate;
    test_reset_mid;
`ifdef UART_TX_CTS_EN
    test_cts;
`endif
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated transmit FIFO. It is the next-generation TX datapath behind the AXI4-Lite register front end of uart_wrapper. Compared with the fixed 8N1 path, it adds configurable data bits, parity, stop bits, FIFO depth and a runtime baud divisor. Downstream of the register file, upstream of the txd pin.

Parameters:
DATA_BITS, 8, character width; legal 5..8
FIFO_DEPTH, 16, FIFO entries; power of 2, >= 2
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
DIV_WIDTH, 16, width of baud_div

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
tx_en  in  1  permits new frames to start; an in-flight frame always completes
baud_div  in  DIV_WIDTH  bit period = baud_div+1 clk cycles
wr_data  in  DATA_BITS  character to enqueue
wr_valid  in  1  write request
wr_ready  out  1  = !fifo_full
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
fifo_empty  out  1  count == 0
fifo_full  out  1  count == FIFO_DEPTH
busy  out  1  high whenever state != IDLE
tx_done  out  1  1-cycle pulse at end of the last stop bit when no further frame follows
txd  out  1  serial output, idle high, registered

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - txd = 1, busy = 0, tx_done = 0, fifo_count = 0.
  - fifo_empty = 1, fifo_full = 0, wr_ready = 1.
  - FSM = IDLE; FIFO pointers = 0.
- Reset mid-frame: txd returns high at the reset edge and FIFO contents are discarded.
- Write rule:
  - An entry is written when wr_valid && wr_ready at a clk edge.
  - When full, the write is refused even if a pop occurs in the same cycle.
  - A write into an empty FIFO is not bypassed to the FSM; it is visible to the FSM the following cycle.
  - Simultaneous push and pop leaves count unchanged.
- Pointers: wrap modulo FIFO_DEPTH; fifo_count is maintained as an explicit counter.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If !fifo_empty && tx_en: pop the head into the shift register, latch baud_div, go to START.
  - txd goes low on that same edge.
- Latency: write accepted at edge E0 into an empty, idle block → txd low at edge E0+2.
- START: 1 bit period low, then DATA.
- DATA:
  - DATA_BITS bit periods, LSB first.
  - Bit counter runs 0..DATA_BITS-1.
  - Then PARITY if PARITY != 0, else STOP.
- PARITY:
  - 1 bit period.
  - Even: XOR of data bits. Odd: inverted XOR.
  - Computed over DATA_BITS bits only.
- STOP:
  - STOP_BITS bit periods, high.
  - At the final cycle of the last stop bit: if !fifo_empty && tx_en, pop and go directly to START. There is no idle gap; txd goes low on the edge that ends the stop bit.
  - Otherwise go to IDLE and pulse tx_done for exactly that cycle.
- Baud counter:
  - Down-counter of DIV_WIDTH bits, loaded with the latched baud_div at each bit start.
  - The bit ends when the counter equals 0.
  - baud_div = 0 gives 1 clk per bit.
  - Changes to baud_div mid-frame take effect at the next frame.
- tx_en deasserted mid-frame: the frame completes, then the FSM waits in IDLE (tx_done pulses).
- Frame length: 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bit periods.

Optional Feature:
UART_TX_CTS_EN
- Defined:
  - Adds input port cts_n (1 bit, active-low clear-to-send, asynchronous).
  - cts_n passes through a 2-flop synchroniser.
  - A new frame (from IDLE or from the STOP chaining) starts only if tx_en && synchronised cts_n == 0.
  - Deassertion mid-frame does not truncate the frame.
- Undefined: port absent; behaves as cts_n permanently 0.

Test Plan:
1. Reset, DATA_BITS=8, PARITY=0, STOP_BITS=1, baud_div=3; write 0xA5 → txd low at E0+2; line bits (4 clk each) 0,1,0,1,0,0,1,0,1,1; tx_done pulses once at the end of the stop bit; busy high for 40 clks.
2. PARITY=2, 7 data bits; write 0x55 → even parity bit 0. PARITY=1, write 0x55 → parity bit 1. Frame = 10 bit periods.
3. FIFO_DEPTH=4, tx_en=0; write 5 words back-to-back → the first 4 are accepted; wr_ready=0 and fifo_full=1 on the 5th; count=4. Set tx_en=1 → 4 frames with no idle gap between them; a single tx_done after the 4th.
4. STOP_BITS=2, baud_div=0; write 0x00, 0xFF → stop region high for exactly 2 clks between frames; total 22 clks.
5. Assert rst midway through DATA of a frame with 3 words queued → txd=1 and fifo_count=0 at the reset edge; no further frames after release.
6. With UART_TX_CTS_EN: cts_n=1 and one word queued → txd stays high. Drop cts_n at T → start bit at T+3. Raise cts_n mid-frame → the frame completes unchanged.
